// File: rtl/ray_dispatcher.sv
// ray_dispatcher: frame-level initiator for a single RayUnit.
// Walks a width x height frame in raster order and issues one ray per pixel
// over the start/ready/busy handshake. Each ray carries the camera origin,
// an incrementally stepped direction and the pixel's framebuffer address.
// Optional build macro: RAY_DISPATCH_PERF_EN adds perfCycles/perfStalls.
module ray_dispatcher #(
    parameter int POSITION_WIDTH  = 16,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DIM_WIDTH       = 11,
    parameter int BYTES_PER_PIXEL = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               frameStart,
    input  logic [DIM_WIDTH-1:0]               frameWidth,
    input  logic [DIM_WIDTH-1:0]               frameHeight,
    input  logic [ADDRESS_WIDTH-1:0]           frameAddress,
    input  logic [2:0][POSITION_WIDTH-1:0]     cameraQ,
    input  logic [2:0][POSITION_WIDTH-1:0]     baseV,
    input  logic [2:0][POSITION_WIDTH-1:0]     deltaX,
    input  logic [2:0][POSITION_WIDTH-1:0]     deltaY,
    output logic                               frameBusy,
    output logic                               frameDone,
    output logic                               rayStart,
    input  logic                               rayReady,
    input  logic                               rayBusy,
    output logic [2:0][POSITION_WIDTH-1:0]     rayQ,
    output logic [2:0][POSITION_WIDTH-1:0]     rayV,
    output logic [ADDRESS_WIDTH-1:0]           pixelAddress
`ifdef RAY_DISPATCH_PERF_EN
    ,
    output logic [31:0]                        perfCycles,
    output logic [31:0]                        perfStalls
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [DIM_WIDTH-1:0]     DIM_ONE     = DIM_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_STRIDE = ADDRESS_WIDTH'(BYTES_PER_PIXEL);

    state_t                          state_reg;
    logic                            frame_busy_reg;
    logic                            frame_done_reg;
    logic                            drain_first_reg;
    logic [DIM_WIDTH-1:0]            width_reg;
    logic [DIM_WIDTH-1:0]            height_reg;
    logic [DIM_WIDTH-1:0]            x_reg;
    logic [DIM_WIDTH-1:0]            y_reg;
    logic [ADDRESS_WIDTH-1:0]        addr_reg;
    logic [2:0][POSITION_WIDTH-1:0]  ray_q_reg;
    logic [2:0][POSITION_WIDTH-1:0]  cur_v_reg;
    logic [2:0][POSITION_WIDTH-1:0]  row_v_reg;
    logic [2:0][POSITION_WIDTH-1:0]  delta_x_reg;
    logic [2:0][POSITION_WIDTH-1:0]  delta_y_reg;

    logic [2:0][POSITION_WIDTH-1:0]  col_v_next;
    logic [2:0][POSITION_WIDTH-1:0]  row_v_next;
    logic [ADDRESS_WIDTH-1:0]        addr_next;
    logic                            last_col;
    logic                            last_row;
    logic                            accept_frame;
    logic                            accept_ray;

    // Per-component direction steps; each wraps independently.
    for (genvar gi = 0; gi < 3; gi++) begin : g_vec
        assign col_v_next[gi] = cur_v_reg[gi] + delta_x_reg[gi];
        assign row_v_next[gi] = row_v_reg[gi] + delta_y_reg[gi];
    end

    assign addr_next    = addr_reg + ADDR_STRIDE;
    assign last_col     = (x_reg == width_reg - DIM_ONE);
    assign last_row     = (y_reg == height_reg - DIM_ONE);
    assign accept_frame = (state_reg == IDLE) && frameStart;
    assign accept_ray   = (state_reg == ISSUE) && rayReady;

    assign rayStart     = (state_reg == ISSUE);
    assign frameBusy    = frame_busy_reg;
    assign frameDone    = frame_done_reg;
    assign rayQ         = ray_q_reg;
    assign rayV         = cur_v_reg;
    assign pixelAddress = addr_reg;

    // Frame sequencer: latch the frame, walk pixels, drain the RayUnit, report done.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= IDLE;
            frame_busy_reg  <= 1'b0;
            frame_done_reg  <= 1'b0;
            drain_first_reg <= 1'b0;
            width_reg       <= '0;
            height_reg      <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            addr_reg        <= '0;
            ray_q_reg       <= '0;
            cur_v_reg       <= '0;
            row_v_reg       <= '0;
            delta_x_reg     <= '0;
            delta_y_reg     <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (frameStart) begin
                        width_reg   <= frameWidth;
                        height_reg  <= frameHeight;
                        x_reg       <= '0;
                        y_reg       <= '0;
                        addr_reg    <= frameAddress;
                        ray_q_reg   <= cameraQ;
                        cur_v_reg   <= baseV;
                        row_v_reg   <= baseV;
                        delta_x_reg <= deltaX;
                        delta_y_reg <= deltaY;
                        if (frameWidth == '0 || frameHeight == '0) begin
                            // Empty frame: nothing to issue, complete immediately.
                            state_reg      <= DONE;
                            frame_done_reg <= 1'b1;
                            frame_busy_reg <= 1'b0;
                        end else begin
                            state_reg      <= ISSUE;
                            frame_busy_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (rayReady) begin
                        if (last_col && last_row) begin
                            state_reg       <= DRAIN;
                            drain_first_reg <= 1'b1;
                        end else begin
                            addr_reg <= addr_next;
                            if (!last_col) begin
                                x_reg     <= x_reg + DIM_ONE;
                                cur_v_reg <= col_v_next;
                            end else begin
                                x_reg     <= '0;
                                y_reg     <= y_reg + DIM_ONE;
                                row_v_reg <= row_v_next;
                                cur_v_reg <= row_v_next;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Skip one cycle so the RayUnit's busy has time to rise.
                    if (drain_first_reg) begin
                        drain_first_reg <= 1'b0;
                    end else if (!rayBusy) begin
                        state_reg      <= DONE;
                        frame_done_reg <= 1'b1;
                        frame_busy_reg <= 1'b0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef RAY_DISPATCH_PERF_EN
    logic [31:0] perf_cycles_reg;
    logic [31:0] perf_stalls_reg;

    assign perfCycles = perf_cycles_reg;
    assign perfStalls = perf_stalls_reg;

    // Saturating frame-duration and stall counters; hold between frames.
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_cycles_reg <= '0;
            perf_stalls_reg <= '0;
        end else if (accept_frame) begin
            perf_cycles_reg <= 32'd1;
            perf_stalls_reg <= '0;
        end else begin
            if (state_reg != IDLE && perf_cycles_reg != '1) begin
                perf_cycles_reg <= perf_cycles_reg + 32'd1;
            end
            if (state_reg == ISSUE && !rayReady && perf_stalls_reg != '1) begin
                perf_stalls_reg <= perf_stalls_reg + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept_frame | accept_ray;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher: directed tests for ray_dispatcher with a simple
// fixed-latency RayUnit busy model driven from the stimulus thread.
module tb_ray_dispatcher;

    logic                 clock;
    logic                 reset;
    logic                 frameStart;
    logic [10:0]          frameWidth;
    logic [10:0]          frameHeight;
    logic [31:0]          frameAddress;
    logic [2:0][15:0]     cameraQ;
    logic [2:0][15:0]     baseV;
    logic [2:0][15:0]     deltaX;
    logic [2:0][15:0]     deltaY;
    logic                 frameBusy;
    logic                 frameDone;
    logic                 rayStart;
    logic                 rayReady;
    logic                 rayBusy;
    logic [2:0][15:0]     rayQ;
    logic [2:0][15:0]     rayV;
    logic [31:0]          pixelAddress;

    int checks;
    int passes;

    // RayUnit model and monitor state
    int          busy_timer;
    int          cyc;
    int          fall_cyc;
    int          done_cyc;
    int          done_pulses;
    int          start_samples;
    logic [31:0] acc_addr[$];
    logic [47:0] acc_v[$];
    logic [47:0] acc_q[$];

    ray_dispatcher dut (
        .clock        (clock),
        .reset        (reset),
        .frameStart   (frameStart),
        .frameWidth   (frameWidth),
        .frameHeight  (frameHeight),
        .frameAddress (frameAddress),
        .cameraQ      (cameraQ),
        .baseV        (baseV),
        .deltaX       (deltaX),
        .deltaY       (deltaY),
        .frameBusy    (frameBusy),
        .frameDone    (frameDone),
        .rayStart     (rayStart),
        .rayReady     (rayReady),
        .rayBusy      (rayBusy),
        .rayQ         (rayQ),
        .rayV         (rayV),
        .pixelAddress (pixelAddress)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock cycle: record a ray accepted at this edge, advance the
    // RayUnit model, then sample just after the edge.
    task automatic tick();
        logic acc;
        logic prev_busy;
        acc = rayStart && rayReady && reset;
        if (acc) begin
            acc_addr.push_back(pixelAddress);
            acc_v.push_back(rayV);
            acc_q.push_back(rayQ);
        end
        prev_busy = rayBusy;
        @(posedge clock);
        #1;
        cyc++;
        if (acc) busy_timer = 5;
        else if (busy_timer != 0) busy_timer--;
        rayBusy = (busy_timer != 0);
        if (prev_busy && !rayBusy) fall_cyc = cyc;
        if (frameDone) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (rayStart) start_samples++;
    endtask

    task automatic clear_monitor();
        acc_addr.delete();
        acc_v.delete();
        acc_q.delete();
        done_pulses   = 0;
        start_samples = 0;
        fall_cyc      = -1;
        done_cyc      = -1;
    endtask

    task automatic start_frame();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frameDone) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        frameStart   = 1'b1;
        frameWidth   = 11'd4;
        frameHeight  = 11'd4;
        frameAddress = 32'hDEAD_0000;
        cameraQ      = {16'd7, 16'd8, 16'd9};
        baseV        = {16'd1, 16'd2, 16'd3};
        tick();
        tick();
        checks++; if (frameBusy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", frameBusy); else passes++;
        checks++; if (frameDone !== 1'b0) $display("FAIL reset_done got=%b exp=0", frameDone); else passes++;
        checks++; if (rayStart !== 1'b0) $display("FAIL reset_raystart got=%b exp=0", rayStart); else passes++;
        checks++; if (pixelAddress !== 32'h0) $display("FAIL reset_addr got=%h exp=0", pixelAddress); else passes++;
        checks++; if (rayV !== 48'h0) $display("FAIL reset_rayv got=%h exp=0", rayV); else passes++;
        checks++; if (rayQ !== 48'h0) $display("FAIL reset_rayq got=%h exp=0", rayQ); else passes++;
        frameStart = 1'b0;
        reset      = 1'b1;
        tick();
        $display("reset: busy=%b done=%b start=%b", frameBusy, frameDone, rayStart);
    endtask

    task automatic test_raster_addresses();
        bit ok;
        logic [31:0] got;
        logic [47:0] gotq;
        clear_monitor();
        frameWidth   = 11'd3;
        frameHeight  = 11'd2;
        frameAddress = 32'h0000_1000;
        cameraQ      = {16'd3, 16'd2, 16'd1};
        baseV        = {16'd0, 16'd0, 16'd0};
        deltaX       = {16'd0, 16'd0, 16'd1};
        deltaY       = {16'd0, 16'd1, 16'd0};
        rayReady     = 1'b1;
        start_frame();
        checks++; if (frameBusy !== 1'b1) $display("FAIL raster_busy got=%b exp=1", frameBusy); else passes++;
        checks++; if (pixelAddress !== 32'h1000) $display("FAIL raster_first_addr got=%h exp=1000", pixelAddress); else passes++;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (acc_addr.size() !== 6) $display("FAIL back_to_back_count got=%0d exp=6", acc_addr.size()); else passes++;
        wait_done(60, ok);
        checks++; if (!ok) $display("FAIL raster_timeout got=no_done exp=done"); else passes++;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            got  = (i < acc_addr.size()) ? acc_addr[i] : 32'hxxxx_xxxx;
            gotq = (i < acc_q.size()) ? acc_q[i] : 48'hx;
            checks++;
            if (got !== 32'h1000 + 32'(i * 4)) $display("FAIL raster_addr%0d got=%h exp=%h", i, got, 32'h1000 + 32'(i * 4));
            else passes++;
            checks++;
            if (gotq !== {16'd3, 16'd2, 16'd1}) $display("FAIL raster_rayq%0d got=%h exp=%h", i, gotq, {16'd3, 16'd2, 16'd1});
            else passes++;
            $display("raster ray %0d addr=%h", i, got);
        end
        checks++; if (done_cyc !== fall_cyc + 1) $display("FAIL raster_done_timing got=%0d exp=%0d", done_cyc, fall_cyc + 1); else passes++;
        checks++; if (done_pulses !== 1) $display("FAIL raster_done_pulses got=%0d exp=1", done_pulses); else passes++;
        checks++; if (frameBusy !== 1'b0) $display("FAIL raster_busy_after got=%b exp=0", frameBusy); else passes++;
    endtask

    task automatic test_direction_sequence();
        bit ok;
        logic [47:0] exp_v [4];
        logic [47:0] got;
        clear_monitor();
        exp_v[0] = {16'd30, 16'd20, 16'd10};
        exp_v[1] = {16'd30, 16'd20, 16'd11};
        exp_v[2] = {16'd30, 16'd22, 16'd10};
        exp_v[3] = {16'd30, 16'd22, 16'd11};
        frameWidth   = 11'd2;
        frameHeight  = 11'd2;
        frameAddress = 32'h0000_0100;
        baseV        = {16'd30, 16'd20, 16'd10};
        deltaX       = {16'd0, 16'd0, 16'd1};
        deltaY       = {16'd0, 16'd2, 16'd0};
        rayReady     = 1'b1;
        start_frame();
        wait_done(60, ok);
        checks++; if (!ok) $display("FAIL dir_timeout got=no_done exp=done"); else passes++;
        tick();
        checks++; if (acc_v.size() !== 4) $display("FAIL dir_count got=%0d exp=4", acc_v.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            got = (i < acc_v.size()) ? acc_v[i] : 48'hx;
            checks++;
            if (got !== exp_v[i]) $display("FAIL dir_rayv%0d got=%h exp=%h", i, got, exp_v[i]);
            else passes++;
            $display("dir ray %0d rayV=%h", i, got);
        end
    endtask

    task automatic test_zero_size();
        clear_monitor();
        frameWidth  = 11'd0;
        frameHeight = 11'd5;
        frameStart  = 1'b1;
        tick();
        checks++; if (frameDone !== 1'b1) $display("FAIL zero_done got=%b exp=1", frameDone); else passes++;
        checks++; if (frameBusy !== 1'b0) $display("FAIL zero_busy got=%b exp=0", frameBusy); else passes++;
        // frameStart still high while in DONE: must be ignored
        tick();
        frameStart = 1'b0;
        checks++; if (frameDone !== 1'b0) $display("FAIL zero_done_single got=%b exp=0", frameDone); else passes++;
        tick();
        tick();
        checks++; if (start_samples !== 0) $display("FAIL zero_raystart got=%0d exp=0", start_samples); else passes++;
        checks++; if (done_pulses !== 1) $display("FAIL zero_pulses got=%0d exp=1", done_pulses); else passes++;
        $display("zero frame: done_pulses=%0d raystarts=%0d", done_pulses, start_samples);
    endtask

    task automatic test_stalls();
        bit          done_flag;
        bit          prev_stall;
        logic [15:0] pattern;
        logic [31:0] held_addr;
        logic [47:0] held_v;
        logic [47:0] held_q;
        logic [31:0] got;
        clear_monitor();
        pattern      = 16'b1010_0110_0011_1001;
        frameWidth   = 11'd3;
        frameHeight  = 11'd2;
        frameAddress = 32'h0000_2000;
        cameraQ      = {16'h0C0C, 16'h0B0B, 16'h0A0A};
        baseV        = {16'd5, 16'd6, 16'd7};
        deltaX       = {16'd1, 16'd1, 16'd1};
        deltaY       = {16'd2, 16'd0, 16'd0};
        rayReady     = 1'b0;
        start_frame();
        prev_stall = 1'b0;
        done_flag  = 1'b0;
        for (int c = 0; c < 200 && !done_flag; c++) begin
            if (prev_stall && rayStart) begin
                checks++;
                if (pixelAddress !== held_addr) $display("FAIL stall_addr c%0d got=%h exp=%h", c, pixelAddress, held_addr);
                else passes++;
                checks++;
                if (rayV !== held_v) $display("FAIL stall_rayv c%0d got=%h exp=%h", c, rayV, held_v);
                else passes++;
                checks++;
                if (rayQ !== held_q) $display("FAIL stall_rayq c%0d got=%h exp=%h", c, rayQ, held_q);
                else passes++;
            end
            rayReady   = pattern[c % 16];
            prev_stall = rayStart && !rayReady;
            held_addr  = pixelAddress;
            held_v     = rayV;
            held_q     = rayQ;
            tick();
            if (frameDone) done_flag = 1'b1;
        end
        checks++; if (!done_flag) $display("FAIL stall_timeout got=no_done exp=done"); else passes++;
        rayReady = 1'b1;
        tick();
        checks++; if (acc_addr.size() !== 6) $display("FAIL stall_count got=%0d exp=6", acc_addr.size()); else passes++;
        for (int i = 0; i < 6; i++) begin
            got = (i < acc_addr.size()) ? acc_addr[i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== 32'h2000 + 32'(i * 4)) $display("FAIL stall_addr%0d got=%h exp=%h", i, got, 32'h2000 + 32'(i * 4));
            else passes++;
            $display("stall ray %0d addr=%h", i, got);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [47:0] got;
        clear_monitor();
        frameWidth   = 11'd2;
        frameHeight  = 11'd1;
        frameAddress = 32'hFFFF_FFFC;
        baseV        = {16'd0, 16'd0, 16'hFFFF};
        deltaX       = {16'd0, 16'd0, 16'd1};
        deltaY       = {16'd0, 16'd0, 16'd0};
        rayReady     = 1'b1;
        start_frame();
        wait_done(60, ok);
        checks++; if (!ok) $display("FAIL wrap_timeout got=no_done exp=done"); else passes++;
        tick();
        got = (acc_v.size() > 1) ? acc_v[1] : 48'hx;
        checks++; if (got !== 48'h0) $display("FAIL wrap_rayv got=%h exp=0", got); else passes++;
        checks++;
        if (acc_addr.size() < 2 || acc_addr[1] !== 32'h0000_0000)
            $display("FAIL wrap_addr got=%h exp=0", (acc_addr.size() > 1) ? acc_addr[1] : 32'hxxxx_xxxx);
        else passes++;
        $display("wrap: second rayV=%h", got);
    endtask

    task automatic test_reset_abort();
        bit ok;
        clear_monitor();
        frameWidth   = 11'd4;
        frameHeight  = 11'd4;
        frameAddress = 32'h0000_3000;
        baseV        = {16'd9, 16'd8, 16'd7};
        deltaX       = {16'd0, 16'd0, 16'd1};
        deltaY       = {16'd0, 16'd1, 16'd0};
        rayReady     = 1'b1;
        start_frame();
        tick();
        tick();
        // third ray now presented
        checks++; if (pixelAddress !== 32'h3008) $display("FAIL abort_third_addr got=%h exp=3008", pixelAddress); else passes++;
        reset = 1'b0;
        tick();
        checks++; if (rayStart !== 1'b0) $display("FAIL abort_raystart got=%b exp=0", rayStart); else passes++;
        checks++; if (frameBusy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", frameBusy); else passes++;
        reset = 1'b1;
        tick();
        checks++; if (rayStart !== 1'b0) $display("FAIL abort_idle got=%b exp=0", rayStart); else passes++;
        clear_monitor();
        start_frame();
        wait_done(120, ok);
        checks++; if (!ok) $display("FAIL restart_timeout got=no_done exp=done"); else passes++;
        tick();
        checks++; if (acc_addr.size() !== 16) $display("FAIL restart_count got=%0d exp=16", acc_addr.size()); else passes++;
        checks++;
        if (acc_addr.size() < 1 || acc_addr[0] !== 32'h3000 || acc_v[0] !== {16'd9, 16'd8, 16'd7})
            $display("FAIL restart_first got=%h exp=3000", (acc_addr.size() > 0) ? acc_addr[0] : 32'hxxxx_xxxx);
        else passes++;
        checks++;
        if (acc_addr.size() < 16 || acc_addr[15] !== 32'h303C)
            $display("FAIL restart_last got=%h exp=303c", (acc_addr.size() > 15) ? acc_addr[15] : 32'hxxxx_xxxx);
        else passes++;
        $display("restart: rays=%0d", acc_addr.size());
    endtask

    initial begin
        checks       = 0;
        passes       = 0;
        busy_timer   = 0;
        cyc          = 0;
        rayBusy      = 1'b0;
        rayReady     = 1'b1;
        frameStart   = 1'b0;
        frameWidth   = '0;
        frameHeight  = '0;
        frameAddress = '0;
        cameraQ      = '0;
        baseV        = '0;
        deltaX       = '0;
        deltaY       = '0;
        reset        = 1'b0;
        clear_monitor();
        test_reset();
        test_raster_addresses();
        test_direction_sequence();
        test_zero_size();
        test_stalls();
        test_wrap();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
